// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Queued bytes go out back-to-back, LSB first, one IDLE cycle apart.
module uart_tx_fifo #(
    parameter int BAUD_DIV = 2604,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       busy,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [11:0]   BAUD_MAX = 12'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_TX} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [9:0]    r_shift;
    logic [11:0]   r_baud;
    logic [3:0]    r_bit;
    logic          r_done;
    logic          w_push;
    logic          w_load;
    logic          w_shift;
    logic          w_fin;

    assign full    = (r_count == CNT_FULL);
    assign empty   = (r_count == '0);
    assign w_push  = trmt & ~full;
    assign busy    = (r_state == S_TX);
    assign TX      = r_shift[0];
    assign tx_done = r_done;

    // FIFO storage; no reset needed, validity tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= tx_data;
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_load)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_load)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_load)
                r_count <= r_count - CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and per-cycle frame controls
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_fin   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!empty) begin
                    w_load = 1'b1;
                    w_next = S_TX;
                end
            end
            S_TX: begin
                if (r_bit == 4'd10) begin
                    w_fin  = 1'b1;
                    w_next = S_IDLE;
                end else if (r_baud == BAUD_MAX) begin
                    w_shift = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shift register, baud and bit counters; ones fill behind the stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '1;
            r_baud  <= '0;
            r_bit   <= '0;
        end else if (w_load) begin
            r_shift <= {1'b1, r_mem[r_rptr], 1'b0};
            r_baud  <= '0;
            r_bit   <= '0;
        end else if (w_shift) begin
            r_shift <= {1'b1, r_shift[9:1]};
            r_baud  <= '0;
            r_bit   <= r_bit + 4'd1;
        end else if (busy) begin
            r_baud  <= r_baud + 12'd1;
        end
    end

    // Sticky completion flag, cleared when the next frame loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_done <= 1'b0;
        else if (w_fin)
            r_done <= 1'b1;
        else if (w_load)
            r_done <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// A line monitor decodes frames at bit centres and queues them.
module tb_uart_tx_fifo;
    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       busy;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int epoch    = 0;

    logic [7:0] exp_q [$];
    logic [9:0] rx_q [$];
    int         fall_q [$];

    logic [9:0] m_fr;
    int         m_ep;

    uart_tx_fifo #(.BAUD_DIV(B), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .busy    (busy),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge rst_n) epoch <= epoch + 1;

    // Line monitor: frames cut short by reset are discarded
    always begin
        @(negedge TX);
        m_ep = epoch;
        #1;
        fall_q.push_back(cyc);
        repeat (B / 2) @(posedge clk);
        #1 m_fr[0] = TX;
        for (int k = 1; k < 10; k++) begin
            repeat (B) @(posedge clk);
            #1 m_fr[k] = TX;
        end
        if (m_ep == epoch)
            rx_q.push_back(m_fr);
    end

    task automatic push(input logic [7:0] b, input bit accept);
        @(negedge clk);
        trmt    = 1'b1;
        tx_data = b;
        if (accept)
            exp_q.push_back(b);
        @(posedge clk);
        #1;
    endtask

    task automatic release_trmt();
        @(negedge clk);
        trmt = 1'b0;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int g = 0;
        while (rx_q.size() < n && g < n * 200 + 400) begin
            @(negedge clk);
            g++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_falls(input int n, output bit ok);
        int g = 0;
        while (fall_q.size() < n && g < n * 200 + 400) begin
            @(negedge clk);
            g++;
        end
        ok = (fall_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        trmt    = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", TX); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    endtask

    task automatic test_single();
        bit ok;
        logic [9:0] fr;
        fall_q.delete();
        push(8'hA5, 1'b1);
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_T_empty: got %b want 0", empty); end
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL single_T_tx: got %b want 1", TX); end
        release_trmt();
        @(posedge clk); #1;
        n_checks++; if (TX !== 1'b0) begin n_fail++; $display("FAIL single_T1_tx: got %b want 0", TX); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_T1_busy: got %b want 1", busy); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_T1_empty: got %b want 1", empty); end
        repeat (160) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_T161_busy: got %b want 1", busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL single_T161_done: got %b want 0", tx_done); end
        @(posedge clk); #1;
        n_checks++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL single_T162_done: got %b want 1", tx_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_T162_busy: got %b want 0", busy); end
        wait_rx(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL single_rx_timeout: got %0d frames want 1", rx_q.size());
        end else begin
            fr = rx_q.pop_front();
            void'(exp_q.pop_front());
            if (fr !== 10'b1101001010) begin n_fail++; $display("FAIL single_bits: got %b want 1101001010", fr); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [9:0] fr;
        logic [7:0] eb;
        fall_q.delete();
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h3C, 1'b1);
        release_trmt();
        wait_falls(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_fall2_timeout: got %0d want 2", fall_q.size()); end
        if (ok) begin
            n_checks++; if (fall_q[1] - fall_q[0] !== 162) begin n_fail++; $display("FAIL b2b_period1: got %0d want 162", fall_q[1] - fall_q[0]); end
            n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_clr: got %b want 0", tx_done); end
        end
        wait_falls(3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_fall3_timeout: got %0d want 3", fall_q.size()); end
        if (ok) begin
            n_checks++; if (fall_q[2] - fall_q[1] !== 162) begin n_fail++; $display("FAIL b2b_period2: got %0d want 162", fall_q[2] - fall_q[1]); end
            n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
        end
        wait_rx(3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_rx_timeout: got %0d want 3", rx_q.size()); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                fr = rx_q.pop_front();
                eb = exp_q.pop_front();
                n_checks++;
                if (fr !== {1'b1, eb, 1'b0}) begin n_fail++; $display("FAIL b2b_frame%0d: got %b want %b", i, fr, {1'b1, eb, 1'b0}); end
            end
        end
        repeat (100) @(negedge clk);
        n_checks++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_sticky: got %b want 1", tx_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [9:0] fr;
        logic [7:0] eb;
        push(8'h11, 1'b1);
        release_trmt();
        repeat (2) @(negedge clk);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        push(8'h44, 1'b1);
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_full3: got %b want 0", full); end
        push(8'h55, 1'b1);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full4: got %b want 1", full); end
        push(8'h66, 1'b0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_drop: got %b want 1", full); end
        release_trmt();
        wait_rx(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_rx_timeout: got %0d want 5", rx_q.size()); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                fr = rx_q.pop_front();
                eb = exp_q.pop_front();
                n_checks++;
                if (fr !== {1'b1, eb, 1'b0}) begin n_fail++; $display("FAIL ovf_frame%0d: got %b want %b", i, fr, {1'b1, eb, 1'b0}); end
            end
        end
        repeat (300) @(negedge clk);
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL ovf_extra_frame: got %0d want 0", rx_q.size()); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", empty); end
    endtask

    task automatic test_push_pop();
        bit ok;
        int la;
        int g;
        logic [9:0] fr;
        logic [7:0] eb;
        fall_q.delete();
        push(8'hA1, 1'b1);
        release_trmt();
        push(8'hB2, 1'b1);
        push(8'hC3, 1'b1);
        release_trmt();
        wait_falls(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pp_fall1_timeout: got %0d want 1", fall_q.size()); end
        la = ok ? fall_q[0] : cyc;
        g = 0;
        while (cyc < la + 160 && g < 400) begin
            @(negedge clk);
            g++;
        end
        push(8'hD4, 1'b1);
        push(8'hE5, 1'b1);
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL pp_full3: got %b want 0", full); end
        push(8'hF6, 1'b1);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full4: got %b want 1", full); end
        release_trmt();
        wait_falls(2, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pp_fall2_timeout: got %0d want 2", fall_q.size()); end
        else if (fall_q[1] - fall_q[0] !== 162) begin n_fail++; $display("FAIL pp_period: got %0d want 162", fall_q[1] - fall_q[0]); end
        wait_rx(6, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pp_rx_timeout: got %0d want 6", rx_q.size()); end
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                fr = rx_q.pop_front();
                eb = exp_q.pop_front();
                n_checks++;
                if (fr !== {1'b1, eb, 1'b0}) begin n_fail++; $display("FAIL pp_frame%0d: got %b want %b", i, fr, {1'b1, eb, 1'b0}); end
            end
        end
        repeat (200) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int l;
        int g;
        fall_q.delete();
        push(8'hEF, 1'b1);
        push(8'h81, 1'b1);
        push(8'h7E, 1'b1);
        release_trmt();
        wait_falls(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_fall_timeout: got %0d want 1", fall_q.size()); end
        l = ok ? fall_q[0] : cyc;
        g = 0;
        while (cyc < l + 5 * B + 8 && g < 400) begin
            @(negedge clk);
            g++;
        end
        n_checks++; if (TX !== 1'b0) begin n_fail++; $display("FAIL rst_bit4_line: got %b want 0", TX); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", TX); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fall_q.delete();
        repeat (400) @(negedge clk);
        n_checks++; if (fall_q.size() !== 0) begin n_fail++; $display("FAIL rst_residual_start: got %0d want 0", fall_q.size()); end
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL rst_residual_frame: got %0d want 0", rx_q.size()); end
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL rst_after_tx: got %b want 1", TX); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
